// File: rtl/button_conditioner.sv
// Conditions the five raw board buttons: 2-FF synchronise, debounce, detect rising edges.
// Also derives the Pac-Man direction register and the pause toggle from the debounced rises.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnP,
  output logic [4:0] btn_level,
  output logic [4:0] btn_rise,
  output logic [1:0] dir,
  output logic       dir_change,
  output logic       pause
);

  localparam int NB = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    stable_q, stable_d;
  logic [NB-1:0]    rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

  logic [1:0] dir_q, dir_d;
  logic       dir_change_q, dir_change_d;
  logic       pause_q, pause_d;

  logic       vert_ok, horz_ok, req_vld;
  logic [1:0] req_dir;

  // Bit order {P,D,R,L,U}
  assign raw = {btnP, btnD, btnR, btnL, btnU};

  // Debounce: a mismatch must persist DEBOUNCE_CYCLES samples before the level flips
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Opposing rises in the same cycle cancel; vertical wins over horizontal
  always_comb begin
    vert_ok      = rise_q[0] ^ rise_q[3];
    horz_ok      = rise_q[1] ^ rise_q[2];
    req_vld      = vert_ok | horz_ok;
    req_dir      = vert_ok ? (rise_q[0] ? DIR_UP : DIR_DOWN)
                           : (rise_q[1] ? DIR_LEFT : DIR_RIGHT);
    dir_change_d = req_vld && !pause_q && (req_dir != dir_q);
    dir_d        = dir_change_d ? req_dir : dir_q;
    pause_d      = pause_q ^ rise_q[4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      rise_q       <= '0;
      dir_q        <= DIR_RIGHT;
      dir_change_q <= 1'b0;
      pause_q      <= 1'b0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      rise_q       <= rise_d;
      dir_q        <= dir_d;
      dir_change_q <= dir_change_d;
      pause_q      <= pause_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level  = stable_q;
  assign btn_rise   = rise_q;
  assign dir        = dir_q;
  assign dir_change = dir_change_q;
  assign pause      = pause_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations, then random
// button activity compared every cycle against a sample-window reference model.
module tb_button_conditioner;

  localparam int DC = 4;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] raw = '0;
  logic [4:0] btn_level, btn_rise;
  logic [1:0] dir;
  logic       dir_change, pause;

  int total = 0;
  int bad   = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .btnU(raw[0]), .btnL(raw[1]), .btnR(raw[2]), .btnD(raw[3]), .btnP(raw[4]),
    .btn_level(btn_level), .btn_rise(btn_rise), .dir(dir),
    .dir_change(dir_change), .pause(pause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: hist[i][j] is the raw level sampled j edges ago. The debouncer sees
  // the raw value two edges late, so the level flips when the DC samples taken 2..DC+1
  // edges ago all disagree with the current level.
  logic [DC+1:0] hist [5];
  logic [4:0]    m_level, m_rise;
  logic [1:0]    m_dir;
  logic          m_chg, m_pause, ready = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) hist[i] = '0;
      m_level = '0; m_rise = '0; m_dir = 2'b01; m_chg = 1'b0; m_pause = 1'b0;
      ready = 1'b1;
    end else begin
      logic       has;
      logic [1:0] req;
      logic       all_diff;
      has = 1'b0; req = 2'b00;
      if (m_rise[0] != m_rise[3]) begin has = 1'b1; req = m_rise[0] ? 2'b00 : 2'b11; end
      else if (m_rise[1] != m_rise[2]) begin has = 1'b1; req = m_rise[1] ? 2'b10 : 2'b01; end
      m_chg = has && !m_pause && (req != m_dir);
      if (m_chg) m_dir = req;
      if (m_rise[4]) m_pause = !m_pause;
      m_rise = '0;
      for (int i = 0; i < 5; i++) begin
        hist[i] = {hist[i][DC:0], raw[i]};
        all_diff = 1'b1;
        for (int j = 2; j < DC + 2; j++)
          if (hist[i][j] == m_level[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[i] = ~m_level[i];
          m_rise[i]  = m_level[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      chk("level", {3'b0, btn_level}, {3'b0, m_level});
      chk("rise",  {3'b0, btn_rise},  {3'b0, m_rise});
      chk("dir",   {6'b0, dir},       {6'b0, m_dir});
      chk("dchg",  {7'b0, dir_change}, {7'b0, m_chg});
      chk("pause", {7'b0, pause},     {7'b0, m_pause});
    end
  end

  task automatic set_raw(input logic [4:0] v);
    @(negedge clk);
    raw = v;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] v);
    set_raw(v);
    edges(10);
    set_raw(5'b0);
    edges(10);
  endtask

  initial begin
    int cnt, at;
    int hold [5];

    // Reset held for two edges with btnR already pressed
    edges(1);
    set_raw(5'b00100);
    edges(2);
    chk("rst_dir",   {6'b0, dir}, 8'h01);
    chk("rst_pause", {7'b0, pause}, 8'h00);
    chk("rst_level", {3'b0, btn_level}, 8'h00);
    chk("rst_rise",  {3'b0, btn_rise}, 8'h00);
    @(negedge clk); reset = 1'b0;
    edges(5);
    chk("r_rise_e5", {7'b0, btn_rise[2]}, 8'h00);
    edges(1);
    chk("r_rise_e6", {3'b0, btn_rise}, 8'h04);
    chk("r_lvl_e6",  {3'b0, btn_level}, 8'h04);
    edges(1);
    chk("r_rise_e7", {3'b0, btn_rise}, 8'h00);
    chk("r_chg_e7",  {7'b0, dir_change}, 8'h00);
    set_raw(5'b0);
    edges(10);

    // Single U press, then a 3-cycle L glitch
    set_raw(5'b00001);
    edges(6);
    chk("u_rise_e6", {3'b0, btn_rise}, 8'h01);
    edges(1);
    chk("u_dir_e7", {6'b0, dir}, 8'h00);
    chk("u_chg_e7", {7'b0, dir_change}, 8'h01);
    edges(1);
    chk("u_chg_e8", {7'b0, dir_change}, 8'h00);
    set_raw(5'b0);
    edges(10);
    set_raw(5'b00010);
    edges(3);
    set_raw(5'b0);
    edges(10);
    chk("glitch_lvl", {3'b0, btn_level}, 8'h00);
    chk("glitch_dir", {6'b0, dir}, 8'h00);

    // Simultaneous presses
    press(5'b00110);
    chk("lr_dir", {6'b0, dir}, 8'h00);
    press(5'b01001);
    chk("ud_dir", {6'b0, dir}, 8'h00);
    press(5'b00100);
    chk("r_dir", {6'b0, dir}, 8'h01);
    press(5'b00011);
    chk("ul_dir", {6'b0, dir}, 8'h00);

    // Pause gating
    set_raw(5'b10000);
    edges(6);
    chk("p_e6", {7'b0, pause}, 8'h00);
    edges(1);
    chk("p_e7", {7'b0, pause}, 8'h01);
    set_raw(5'b0);
    edges(10);
    press(5'b01000);
    chk("pd_dir", {6'b0, dir}, 8'h00);
    press(5'b10000);
    chk("unpause", {7'b0, pause}, 8'h00);
    press(5'b01000);
    chk("d_dir", {6'b0, dir}, 8'h03);

    // Bounce then settle high: exactly one rise, 6 edges after settling
    for (int k = 0; k < 10; k++) set_raw((k % 2 == 0) ? 5'b01000 : 5'b00000);
    set_raw(5'b01000);
    cnt = 0; at = 0;
    for (int i = 1; i <= 14; i++) begin
      edges(1);
      if (btn_rise[3]) begin cnt++; at = i; end
    end
    chk("bnc_cnt", cnt[7:0], 8'd1);
    chk("bnc_at",  at[7:0],  8'd6);
    set_raw(5'b0);
    edges(10);
    set_raw(5'b01000);
    cnt = 0; at = 0;
    for (int i = 1; i <= 14; i++) begin
      edges(1);
      if (i == 5) raw = 5'b0;
      if (btn_rise[3]) begin cnt++; at = i; end
    end
    chk("repress_cnt", cnt[7:0], 8'd1);
    chk("repress_at",  at[7:0],  8'd6);
    edges(10);

    // Reset while btnR counter is mid-count
    set_raw(5'b00100);
    edges(4);
    @(negedge clk); reset = 1'b1;
    edges(1);
    chk("mid_lvl",  {3'b0, btn_level}, 8'h00);
    chk("mid_rise", {3'b0, btn_rise}, 8'h00);
    @(negedge clk); reset = 1'b0;
    edges(5);
    chk("mid_e5", {7'b0, btn_rise[2]}, 8'h00);
    edges(1);
    chk("mid_e6", {7'b0, btn_rise[2]}, 8'h01);
    set_raw(5'b0);
    edges(10);

    // Random segments of held levels (short segments act as bounce), occasional reset
    for (int i = 0; i < 5; i++) hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (hold[i] == 0) begin
          raw[i]  = 1'($urandom_range(1, 0));
          hold[i] = $urandom_range(12, 1);
        end else begin
          hold[i]--;
        end
      end
      reset = ($urandom_range(399, 0) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    raw = '0;
    edges(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
